perceptron_engine: RTL and testbench
====================================

# perceptron_engine

Perceptron compute-and-train stage sitting directly downstream of the SPI receiver in the branch predictor. On each received branch record it reads the selected perceptron's weights from the shared 128-byte latch memory, computes the dot product against the global history register, and emits the taken/not-taken prediction. It then trains the weights against the ground-truth direction and shifts that direction into the history.

## Interface
Parameters:
- `HISTORY_LENGTH`, 15: global history bits; weights per perceptron, excluding the bias.
- `NUM_PERCEPTRONS`, 8: perceptrons in memory. Each uses HISTORY_LENGTH+1 bytes; the product must be at most 128.
- `ADDR_BITS`, 16: width of `inst_addr`.
- `THETA`, 42: training threshold, floor(1.93*HISTORY_LENGTH+14).

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse from the SPI receiver's `data_input_done`.
- `inst_addr`, in, ADDR_BITS: branch address. Sampled on `start`.
- `direction_ground_truth`, in, 1: actual outcome. Sampled on `start`.
- `mem_addr`, out, 7: latch-memory byte address.
- `mem_wr_en`, out, 1: write strobe, one cycle per byte.
- `mem_wdata`, out, 8: write data.
- `mem_rdata`, in, 8: read data, valid the cycle after `mem_addr` is presented.
- `busy`, out, 1: high outside IDLE.
- `pred_valid`, out, 1: one-cycle pulse qualifying `prediction`.
- `prediction`, out, 1: 1 means taken. Held until the next `pred_valid`.
- `done`, out, 1: one-cycle pulse at the end of a record.

## Operation
- States: CLEAR, IDLE, READ, PREDICT, TRAIN_RD, TRAIN_WR, FINISH.
- **Reset state:**
  - All outputs are 0; `busy` is 1 because the FSM is in CLEAR.
  - History register is all 0 (not-taken).
  - FSM enters CLEAR.
- **CLEAR:** writes 0x00 to addresses 0..127, one per cycle, then goes to IDLE.
- **IDLE:** `start` latches the perceptron index, truth bit t, and a history snapshot.
  - Perceptron index p = (inst_addr>>2) mod NUM_PERCEPTRONS.
  - Base address is p*(HISTORY_LENGTH+1). Weight k sits at base+k; k=0 is the bias.
  - `start` is ignored while `busy` is high.
- **READ:** issues addresses base+0 .. base+HISTORY_LENGTH, one per cycle. Each returned byte w_k (signed 8-bit) updates the accumulator y:
  - bias: y += w_0.
  - weight k≥1: y += w_k if h[k-1]=1, else y −= w_k.
- **Accumulator:** y is signed, 13 bits. Range is ±16*128, so overflow is impossible, including −(−128)=+128.
- **PREDICT:** `prediction` = (y ≥ 0); `pred_valid` pulses.
  - Train if `prediction` ≠ t, or if |y| ≤ THETA.
  - If no training is needed, go to FINISH.
- **TRAIN:** for each k, a TRAIN_RD cycle (re-read) is followed by a TRAIN_WR cycle (write).
  - Target x_k is 1 for the bias and h[k-1] otherwise.
  - w_k += +1 if t equals x_k, else −1.
  - The result saturates to [−128, +127]; a weight at a limit stays there.
- **FINISH:** history = {history[HISTORY_LENGTH-2:0], t}; `done` pulses; go to IDLE.
- Reset asserted mid-operation aborts immediately. The FSM re-enters CLEAR, and any partially written memory is overwritten.

## Timing
- `start` is sampled at edge 0.
- READ issues address k during cycle k+1. Its data is accumulated at the end of cycle k+2.
- `pred_valid` is high in cycle HISTORY_LENGTH+3 (cycle 18 at defaults).
- **Without training:** `done` is high in cycle 19; `busy` falls in cycle 20.
- **With training:** adds 2*(HISTORY_LENGTH+1) cycles (32 at defaults); `done` is high in cycle 51.
- CLEAR occupies 128 cycles after reset release. The first `start` is accepted in cycle 129.
- During READ and TRAIN_RD, `mem_wr_en` is 0. During TRAIN_WR, `mem_addr` and `mem_wdata` are stable for the whole cycle.
- A `start` arriving in the same cycle as `done` is ignored.

## Structure
- Package `branch_pred_pkg` holds:
  - the state enum;
  - RAM_BYTES=128 and MEM_ADDR_W=7;
  - WEIGHT_W=8 and ACC_W=13;
  - the WEIGHT_MAX and WEIGHT_MIN constants.
- Sub-module `weight_sat_update`: combinational signed ±1 step with saturation, taking w, t and x_k. This sub-module is reused by the later on-chip readback path.

## Test plan
- **Reset then clear:** release reset → 128 writes of 0x00 to addresses 0..127, `busy` 1 then 0, `prediction` 0.
- **Fresh weights:** start with inst_addr=0x0004, t=1 →
  - p=1, reads at addresses 16..31, y=0, `prediction`=1 in cycle 18;
  - trains because |y| ≤ THETA: bias is written as 0x01, and every weight is written 0xFF since history is 0 and t=1;
  - `done` in cycle 51.
- **Confident correct:**
  - preload p=0 with bias=+100 and weights=0; start with t=1;
  - expect y=100 and `prediction`=1;
  - expect no training writes and `done` in cycle 19.
- **Saturation:**
  - preload bias=0x7F and weights=0x80, history=all 1 (so y=127−1920<0);
  - start with t=1 → `prediction`=0 (misprediction), so training runs;
  - bias stays 0x7F and weights become 0x81.
- **History shift:** three records with t=1,0,1 → history LSBs are 101; the next READ applies the signs accordingly.
- **Busy and reset:**
  - `start` during TRAIN is ignored, with no extra `pred_valid`;
  - asserting `rst_n` low at cycle 25 → outputs go to 0 at once, and CLEAR restarts at address 0.

Source files
------------

// File: rtl/branch_pred_pkg.sv
// Shared types and constants for the perceptron branch predictor datapath.
package branch_pred_pkg;

  typedef enum logic [2:0] {
    CLEAR    = 3'd0,
    IDLE     = 3'd1,
    READ     = 3'd2,
    PREDICT  = 3'd3,
    TRAIN_RD = 3'd4,
    TRAIN_WR = 3'd5,
    FINISH   = 3'd6
  } state_e;

  localparam int RAM_BYTES  = 128;
  localparam int MEM_ADDR_W = 7;
  localparam int WEIGHT_W   = 8;
  localparam int ACC_W      = 13;

  localparam logic signed [WEIGHT_W-1:0] WEIGHT_MAX = 8'sh7F;
  localparam logic signed [WEIGHT_W-1:0] WEIGHT_MIN = 8'sh80;

  // Sign-extend a stored weight byte to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_weight(input logic [WEIGHT_W-1:0] w);
    return {{(ACC_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
  endfunction

endpackage

// File: rtl/perceptron_engine_if.sv
// Bundle of the record handshake, result strobes and latch-memory bus.
//
// Handshake: start is a one-cycle request pulse carrying inst_addr and
// direction_ground_truth; it is accepted only on a cycle where busy is low
// (there is no backpressure, a start seen while busy is dropped). Results are
// qualified by one-cycle pulses: pred_valid qualifies prediction, done marks
// the end of the record. Memory reads return mem_rdata one cycle after
// mem_addr; a write happens on every cycle mem_wr_en is high.
interface perceptron_engine_if
  import branch_pred_pkg::*;
#(
  parameter int ADDR_BITS = 16
);
  logic                  start;
  logic [ADDR_BITS-1:0]  inst_addr;
  logic                  direction_ground_truth;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic                  mem_wr_en;
  logic [WEIGHT_W-1:0]   mem_wdata;
  logic [WEIGHT_W-1:0]   mem_rdata;
  logic                  busy;
  logic                  pred_valid;
  logic                  prediction;
  logic                  done;
  state_e                dbg_state;

  modport master (
    output start, inst_addr, direction_ground_truth, mem_rdata,
    input  mem_addr, mem_wr_en, mem_wdata, busy, pred_valid, prediction, done, dbg_state
  );

  modport slave (
    input  start, inst_addr, direction_ground_truth, mem_rdata,
    output mem_addr, mem_wr_en, mem_wdata, busy, pred_valid, prediction, done, dbg_state
  );
endinterface

// File: rtl/weight_sat_update.sv
// Signed +/-1 weight step with saturation at the 8-bit limits.
module weight_sat_update
  import branch_pred_pkg::*;
(
  input  logic [WEIGHT_W-1:0] w,
  input  logic                t,
  input  logic                x,
  output logic [WEIGHT_W-1:0] w_next
);

  // Step towards agreement with the outcome; a weight at a limit stays put.
  always_comb begin
    w_next = w;
    if (t == x) begin
      if ($signed(w) != WEIGHT_MAX) w_next = w + 1'b1;
    end else begin
      if ($signed(w) != WEIGHT_MIN) w_next = w - 1'b1;
    end
  end

endmodule

// File: rtl/perceptron_engine.sv
// Perceptron predict-and-train stage: clears the weight memory after reset,
// then per branch record reads one perceptron, predicts, optionally trains
// the weights and shifts the outcome into the global history.
module perceptron_engine
  import branch_pred_pkg::*;
#(
  parameter int HISTORY_LENGTH  = 15,
  parameter int NUM_PERCEPTRONS = 8,   // NUM_PERCEPTRONS*(HISTORY_LENGTH+1) must not exceed 128
  parameter int ADDR_BITS       = 16,
  parameter int THETA           = 42
)(
  input logic                clk,
  input logic                rst_n,
  perceptron_engine_if.slave bus
);

  localparam logic [MEM_ADDR_W-1:0] LAST_K  = MEM_ADDR_W'(HISTORY_LENGTH);
  localparam logic [MEM_ADDR_W-1:0] LAST_B  = MEM_ADDR_W'(RAM_BYTES - 1);
  localparam logic signed [ACC_W-1:0] THETA_P = ACC_W'(THETA);
  localparam logic signed [ACC_W-1:0] THETA_N = -THETA_P;

  state_e                    state, state_nx;
  logic                      armed;     // low only until the first edge after reset release
  logic [MEM_ADDR_W-1:0]     cnt;       // clear sweep address, or weight index k
  logic [MEM_ADDR_W-1:0]     base;
  logic                      truth;
  logic [HISTORY_LENGTH-1:0] history;   // never changes while busy, so it doubles as the snapshot
  logic signed [ACC_W-1:0]   acc;
  logic                      pred_q;

  logic [ADDR_BITS-1:0]      p_full;
  logic [MEM_ADDR_W-1:0]     base_sel;
  logic [MEM_ADDR_W-1:0]     data_idx;
  logic [HISTORY_LENGTH:0]   hist_shift;
  logic                      x_bit;
  logic signed [ACC_W-1:0]   acc_nx;
  logic [WEIGHT_W-1:0]       w_next;
  logic                      pred_now;
  logic                      train_need;

  // Perceptron selection and the per-byte input term for the current data byte.
  always_comb begin
    p_full     = (bus.inst_addr >> 2) % ADDR_BITS'(NUM_PERCEPTRONS);
    base_sel   = MEM_ADDR_W'(p_full * ADDR_BITS'(HISTORY_LENGTH + 1));
    // READ sees data for the address issued one cycle earlier; TRAIN_WR sees its own.
    data_idx   = (state == TRAIN_WR) ? cnt : cnt - 1'b1;
    hist_shift = {history, 1'b1} >> data_idx;
    x_bit      = hist_shift[0];
    acc_nx     = x_bit ? acc + sext_weight(bus.mem_rdata) : acc - sext_weight(bus.mem_rdata);
    pred_now   = ~acc[ACC_W-1];
    train_need = (pred_now != truth) || ((acc <= THETA_P) && (acc >= THETA_N));
  end

  weight_sat_update u_sat (
    .w      (bus.mem_rdata),
    .t      (truth),
    .x      (x_bit),
    .w_next (w_next)
  );

  // State register; armed holds off the clear sweep while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
    end
  end

  // Next-state and memory bus drive.
  always_comb begin
    state_nx      = state;
    bus.mem_addr  = '0;
    bus.mem_wr_en = 1'b0;
    bus.mem_wdata = '0;
    case (state)
      CLEAR: begin
        bus.mem_addr  = cnt;
        bus.mem_wr_en = armed;
        if (armed && cnt == LAST_B) state_nx = IDLE;
      end
      IDLE: begin
        if (bus.start) state_nx = READ;
      end
      READ: begin
        bus.mem_addr = base + cnt;
        if (cnt == LAST_K + 1'b1) state_nx = PREDICT;
      end
      PREDICT: begin
        state_nx = train_need ? TRAIN_RD : FINISH;
      end
      TRAIN_RD: begin
        bus.mem_addr = base + cnt;
        state_nx     = TRAIN_WR;
      end
      TRAIN_WR: begin
        bus.mem_addr  = base + cnt;
        bus.mem_wr_en = 1'b1;
        bus.mem_wdata = w_next;
        state_nx      = (cnt == LAST_K) ? FINISH : TRAIN_RD;
      end
      FINISH: begin
        state_nx = IDLE;
      end
      default: state_nx = CLEAR;
    endcase
  end

  // Datapath: sweep counter, record capture, accumulation, history shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      base    <= '0;
      truth   <= 1'b0;
      acc     <= '0;
      pred_q  <= 1'b0;
      history <= '0;
    end else begin
      case (state)
        CLEAR: if (armed) cnt <= cnt + 1'b1;
        IDLE: begin
          if (bus.start) begin
            base  <= base_sel;
            truth <= bus.direction_ground_truth;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        READ: begin
          if (cnt != '0) acc <= acc_nx;
          cnt <= (cnt == LAST_K + 1'b1) ? '0 : cnt + 1'b1;
        end
        PREDICT:  pred_q  <= pred_now;
        TRAIN_WR: cnt     <= cnt + 1'b1;
        FINISH:   history <= {history[HISTORY_LENGTH-2:0], truth};
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.pred_valid = (state == PREDICT);
  assign bus.prediction = (state == PREDICT) ? pred_now : pred_q;
  assign bus.done       = (state == FINISH);
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_perceptron_engine.sv
// Self-checking bench for perceptron_engine: latch-memory model, reference
// perceptron model, directed vector table and randomized records.
module tb_perceptron_engine;

  localparam int HL    = 15;
  localparam int NP    = 8;
  localparam int AB    = 16;
  localparam int THETA = 42;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  perceptron_engine_if #(.ADDR_BITS(AB)) bus ();

  perceptron_engine #(
    .HISTORY_LENGTH (HL),
    .NUM_PERCEPTRONS(NP),
    .ADDR_BITS      (AB),
    .THETA          (THETA)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // ---------------- latch memory model ----------------
  logic [7:0] tb_mem [128];
  logic       pl_en;
  logic [6:0] pl_addr;
  logic [7:0] pl_data;

  always @(posedge clk) begin
    if (bus.mem_wr_en) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    else if (pl_en)    tb_mem[pl_addr]      <= pl_data;
    bus.mem_rdata <= tb_mem[bus.mem_addr];
  end

  // ---------------- reference model and scoreboard ----------------
  logic [7:0]    ref_mem [128];
  logic [HL-1:0] ref_hist;
  logic [14:0]   exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_mem_image(input string name);
    int diffs = 0;
    for (int i = 0; i < 128; i++) if (tb_mem[i] !== ref_mem[i]) diffs++;
    check(name, diffs, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
    ref_hist = '0;
    exp_q.delete();
  endtask

  // Plain-arithmetic perceptron: dot product, decision, saturating training.
  task automatic model_record(input logic [15:0] addr, input bit t,
                              output bit pred, output int exp_done, output int base);
    int p, y, w, nw;
    bit x, train;
    logic [7:0] b;
    p    = (int'(addr) >> 2) % NP;
    base = p * (HL + 1);
    y    = 0;
    for (int k = 0; k <= HL; k++) begin
      b = ref_mem[base + k];
      w = int'($signed(b));
      x = (k == 0) ? 1'b1 : ref_hist[k-1];
      y += x ? w : -w;
    end
    pred     = (y >= 0);
    train    = (pred != t) || (y <= THETA && y >= -THETA);
    exp_done = train ? (HL + 4 + 2 * (HL + 1)) : (HL + 4);
    if (train) begin
      for (int k = 0; k <= HL; k++) begin
        b  = ref_mem[base + k];
        w  = int'($signed(b));
        x  = (k == 0) ? 1'b1 : ref_hist[k-1];
        nw = w + ((t == x) ? 1 : -1);
        if (nw > 127)  nw = 127;
        if (nw < -128) nw = -128;
        b = nw[7:0];
        ref_mem[base + k] = b;
        exp_q.push_back({7'(base + k), b});
      end
    end
    ref_hist = {ref_hist[HL-2:0], t};
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_byte(input int a, input logic [7:0] d);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = 7'(a);
    pl_data = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic preload(input int base, input logic [7:0] bias, input logic [7:0] w);
    write_byte(base, bias);
    for (int k = 1; k <= HL; k++) write_byte(base + k, w);
  endtask

  task automatic reset_and_clear();
    int nwr, first_wr, idle_cycle, bad;
    bus.start = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(bus.busy), 1);
    check("reset_wr_en", int'(bus.mem_wr_en), 0);
    check("reset_pred_valid", int'(bus.pred_valid), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_prediction", int'(bus.prediction), 0);
    rst_n = 1'b1;
    model_reset();
    nwr = 0; first_wr = -1; idle_cycle = -1; bad = 0;
    for (int n = 1; n <= 140; n++) begin
      @(negedge clk);
      if (bus.mem_wr_en) begin
        if (first_wr < 0) first_wr = n;
        if (int'(bus.mem_addr) != nwr || bus.mem_wdata != 8'h00) bad++;
        nwr++;
      end
      if (!bus.busy && idle_cycle < 0) idle_cycle = n;
      if (bus.prediction || bus.pred_valid || bus.done) bad++;
    end
    check("clear_write_count", nwr, 128);
    check("clear_first_cycle", first_wr, 1);
    check("clear_seq_errors", bad, 0);
    check("clear_idle_cycle", idle_cycle, 129);
    check_mem_image("clear_mem_image");
  endtask

  // One record: edge 0 is the posedge that samples start; cycle n is sampled
  // at the negedge following edge n-1. poke_a/poke_b raise an extra start.
  task automatic run_record(input logic [15:0] addr, input bit t,
                            input int poke_a, input int poke_b,
                            output bit got_pred, output int got_done);
    bit exp_pred, pred_at_done, busy_after;
    int exp_done, base, pv_cnt, pv_cycle, rd_bad;
    logic [14:0] exp_w;
    model_record(addr, t, exp_pred, exp_done, base);
    pv_cnt = 0; pv_cycle = -1; rd_bad = 0; got_done = -1;
    busy_after = 1'b1; got_pred = 1'b0; pred_at_done = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.inst_addr = addr;
    bus.direction_ground_truth = t;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (bus.pred_valid) begin
        pv_cnt++;
        pv_cycle = n;
        got_pred = bus.prediction;
      end
      if (n <= HL + 1 && (int'(bus.mem_addr) != base + n - 1 || bus.mem_wr_en)) rd_bad++;
      if (bus.mem_wr_en) begin
        if (exp_q.size() == 0) check("write_unexpected", int'({bus.mem_addr, bus.mem_wdata}), -1);
        else begin
          exp_w = exp_q.pop_front();
          check("train_write", int'({bus.mem_addr, bus.mem_wdata}), int'(exp_w));
        end
      end
      if (got_done >= 0) begin
        busy_after = bus.busy;
        break;
      end
      if (bus.done) begin
        got_done = n;
        pred_at_done = bus.prediction;
      end
      bus.start = (n == poke_a || n == poke_b);
      bus.inst_addr = bus.start ? 16'h001C : addr;
    end
    bus.start = 1'b0;
    check("pred_valid_count", pv_cnt, 1);
    check("pred_valid_cycle", pv_cycle, HL + 3);
    check("prediction", int'(got_pred), int'(exp_pred));
    check("prediction_held", int'(pred_at_done), int'(exp_pred));
    check("done_cycle", got_done, exp_done);
    check("busy_after_done", int'(busy_after), 0);
    check("read_addr_errors", rd_bad, 0);
    check("missing_writes", exp_q.size(), 0);
    exp_q.delete();
    check_mem_image("record_mem_image");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] addr;
    bit          t;
    bit          prime;      // first drive the history to all ones
    bit          pre;        // preload the perceptron before the record
    logic [7:0]  pre_bias;
    logic [7:0]  pre_w;
    bit          exp_pred;
    int          exp_done;
    logic [7:0]  exp_bias;
    logic [7:0]  exp_w;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   gp;
    int   gd, base;
    logic [15:0] ra;

    vecs[0] = '{16'h0004, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 51, 8'h01, 8'hFF};
    vecs[1] = '{16'h0000, 1'b1, 1'b0, 1'b1, 8'h64, 8'h00, 1'b1, 19, 8'h64, 8'h00};
    vecs[2] = '{16'h0008, 1'b1, 1'b1, 1'b1, 8'h7F, 8'h80, 1'b0, 51, 8'h7F, 8'h81};
    vecs[3] = '{16'h000C, 1'b0, 1'b0, 1'b1, 8'h80, 8'h7F, 1'b1, 51, 8'h80, 8'h7E};

    bus.start = 1'b0;
    bus.inst_addr = '0;
    bus.direction_ground_truth = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    reset_and_clear();

    // Directed vectors: fresh weights, confident-correct, saturation both ends.
    for (int i = 0; i < 4; i++) begin
      base = ((int'(vecs[i].addr) >> 2) % NP) * (HL + 1);
      if (vecs[i].prime) for (int j = 0; j < HL; j++) run_record(16'h001C, 1'b1, 0, 0, gp, gd);
      if (vecs[i].pre) preload(base, vecs[i].pre_bias, vecs[i].pre_w);
      run_record(vecs[i].addr, vecs[i].t, 0, 0, gp, gd);
      check($sformatf("vec%0d_pred", i), int'(gp), int'(vecs[i].exp_pred));
      check($sformatf("vec%0d_done", i), gd, vecs[i].exp_done);
      check($sformatf("vec%0d_bias", i), int'(tb_mem[base]), int'(vecs[i].exp_bias));
      check($sformatf("vec%0d_w1", i), int'(tb_mem[base + 1]), int'(vecs[i].exp_w));
      check($sformatf("vec%0d_wlast", i), int'(tb_mem[base + HL]), int'(vecs[i].exp_w));
    end

    // History shift: outcomes 1,0,1 leave h[2:0]=101, so y = +50 -100 +20 = -30.
    run_record(16'h0014, 1'b1, 0, 0, gp, gd);
    run_record(16'h0014, 1'b0, 0, 0, gp, gd);
    run_record(16'h0014, 1'b1, 0, 0, gp, gd);
    preload(64, 8'h00, 8'h00);
    write_byte(65, 8'h32);
    write_byte(66, 8'h64);
    write_byte(67, 8'h14);
    run_record(16'h0010, 1'b1, 0, 0, gp, gd);
    check("hist_sign_pred", int'(gp), 0);

    // Randomized records over a randomized weight image.
    for (int i = 0; i < 128; i++) write_byte(i, 8'($urandom));
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      run_record(ra, 1'($urandom_range(0, 1)), 0, 0, gp, gd);
    end

    // start while training and on the done cycle must both be dropped.
    preload(96, 8'h00, 8'h00);
    run_record(16'h0018, 1'b0, 30, 51, gp, gd);
    check("busy_poke_done", gd, 51);

    // Reset in the middle of training.
    preload(96, 8'h00, 8'h00);
    @(negedge clk);
    bus.start = 1'b1;
    bus.inst_addr = 16'h0018;
    bus.direction_ground_truth = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("midop_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_wr_en", int'(bus.mem_wr_en), 0);
    check("abort_addr", int'(bus.mem_addr), 0);
    check("abort_wdata", int'(bus.mem_wdata), 0);
    check("abort_pred_valid", int'(bus.pred_valid), 0);
    check("abort_prediction", int'(bus.prediction), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_busy", int'(bus.busy), 1);
    reset_and_clear();
    run_record(16'h0004, 1'b1, 0, 0, gp, gd);
    check("post_reset_pred", int'(gp), 1);
    check("post_reset_done", gd, 51);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
